sawtooth_seq: RTL

SAWTOOTH_SEQ -- requirements
Module: sawtooth_seq

---
 rtl/sawtooth_seq.sv | 117 +++++++++++
 1 files changed

// File: rtl/sawtooth_seq.sv
// Sawtooth generator: a phase accumulator that runs for a commanded number of ramps, or continuously.
// Optional pause input is enabled by defining SAWTOOTH_SEQ_PAUSE_EN.
module sawtooth_seq #(
  parameter int CTR_BITS = 30,
  parameter int VAL_BITS = 7,
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CTR_BITS-1:0] cmd_step,
  input  logic [CNT_BITS-1:0] cmd_ramps,
  input  logic                stop,
`ifdef SAWTOOTH_SEQ_PAUSE_EN
  input  logic                pause,
`endif
  output logic [VAL_BITS-1:0] val,
  output logic                busy,
  output logic                wrap,
  output logic                done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [CTR_BITS-1:0] acc_q, acc_d;
  logic [CTR_BITS-1:0] step_q, step_d;
  logic [CNT_BITS-1:0] ramps_q, ramps_d;
  logic [CNT_BITS-1:0] rem_q, rem_d;
  logic                wrap_q, wrap_d;
  logic                done_q, done_d;
  logic [CTR_BITS:0]   sum;
  logic                carry;
  logic                paused;

`ifdef SAWTOOTH_SEQ_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign sum   = {1'b0, acc_q} + {1'b0, step_q};
  assign carry = sum[CTR_BITS];

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d = state_q;
    acc_d   = acc_q;
    step_d  = step_q;
    ramps_d = ramps_q;
    rem_d   = rem_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // stop is ignored here, even alongside a new command
        if (cmd_valid) begin
          state_d = RUN;
          step_d  = cmd_step;
          ramps_d = cmd_ramps;
          rem_d   = cmd_ramps;
          acc_d   = '0;
        end
      end
      RUN: begin
        if (stop) begin
          // abort wins over a coincident final wrap; the carry is still reported
          state_d = IDLE;
          acc_d   = '0;
          rem_d   = '0;
          wrap_d  = carry && !paused;
        end else if (!paused) begin
          wrap_d = carry;
          acc_d  = sum[CTR_BITS-1:0];
          if (carry && (ramps_q != '0)) begin
            rem_d = rem_q - CNT_BITS'(1);
            if (rem_q == CNT_BITS'(1)) begin
              acc_d   = '0;
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      step_q  <= '0;
      ramps_q <= '0;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      ramps_q <= ramps_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign wrap      = wrap_q;
  assign done      = done_q;
  assign val       = acc_q[CTR_BITS-1 -: VAL_BITS];

endmodule
